mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Sequences all external-memory traffic of the core onto one shared request/ack data bus.
//  Two masters share the bus:
//  - Data port (DM): driven by the mem stage's load/store outputs (ce/we/addr/sel/data).
//  - Instruction port (IM): driven by the fetch stage.
//  The block holds the pipeline with stall requests to ctrl until each access completes.
//  It returns read data to the requesting stage, and converts a bus that never acknowledges into an error pulse.
// PARAMETERS
//  TIMEOUT   16   bus cycles without bus_ack_i before the access is aborted with bus_err_o; 0 = never time out
// PORTS
//  clk             in   1   core clock; the only clock in the block
//  rst             in   1   synchronous reset, active low
//  dm_ce_i         in   1   data access request (mem stage chip enable)
//  dm_we_i         in   1   1 = store; already masked by mem-stage exceptions
//  dm_addr_i       in   32  data byte address
//  dm_sel_i        in   4   byte lanes; bit3 = bits[31:24]
//  dm_data_i       in   32  store data, already lane-replicated
//  dm_data_o       out  32  load data returned to the mem stage
//  im_ce_i         in   1   instruction fetch request
//  im_addr_i       in   32  fetch address (pc)
//  im_data_o       out  32  fetched instruction
//  hold_i          in   1   ctrl is stalling the pipeline for another reason
//  flush_i         in   1   ctrl flush (exception/mret); discard results
//  stallreq_mem_o  out  1   to ctrl: data access not yet complete
//  stallreq_if_o   out  1   to ctrl: fetch not yet complete
//  bus_cyc_o       out  1   bus cycle active
//  bus_stb_o       out  1   bus strobe
//  bus_we_o        out  1   bus write
//  bus_addr_o      out  32  bus address
//  bus_sel_o       out  4   bus byte enables
//  bus_data_o      out  32  bus write data
//  bus_data_i      in   32  bus read data
//  bus_ack_i       in   1   bus acknowledge; one-cycle pulse per access
//  bus_err_o       out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//  - Every output is 0, including dm_data_o, im_data_o and stallreq_*.
//  - State goes to IDLE and the timeout counter clears.
//  - A reset during BUSY abandons the access: bus_cyc_o/bus_stb_o are 0 on the next cycle.
//  Bus outputs and the read buffers are registered. stallreq_* are combinational from state plus the *_ce_i inputs.
//  State machine:
//  - IDLE
//    - flush_i=1: start nothing; stay in IDLE.
//    - else dm_ce_i=1: latch DM fields and go to BUSY_D. DM wins over IM because it is the older instruction.
//    - else im_ce_i=1: latch im_addr_i with sel=4'b1111, we=0, and go to BUSY_I.
//    - bus_cyc_o/bus_stb_o rise in the cycle after the request is seen.
//  - BUSY_D / BUSY_I
//    - cyc=stb=1; addr/sel/we/data are held stable until termination.
//    - On bus_ack_i: cyc=stb=0 next cycle. Capture bus_data_i into the port buffer on reads; stores leave the buffer unchanged.
//      - Go to DONE_D or DONE_I.
//      - If flush_i was seen at any point during BUSY, go to IDLE instead; the buffer is not updated.
//    - On timeout: counter reaches TIMEOUT-1 with no ack.
//      - Buffer loads 32'h0 and bus_err_o pulses for 1 cycle.
//      - Next state is the same as on ack.
//    - flush_i never cuts a transfer short; the transfer always completes on the bus first.
//  - DONE_D / DONE_I
//    - Matching stallreq is 0; *_data_o shows the buffer.
//    - Stay in DONE while hold_i=1.
//    - Go to IDLE on the first cycle with hold_i=0 or flush_i=1.
//  Stall rules:
//  - stallreq_mem_o = dm_ce_i & ~(state==DONE_D).
//  - stallreq_if_o  = im_ce_i & ~(state==DONE_I).
//  - Both are 0 when flush_i=1.
//  Timing and boundaries:
//  - Minimum latency is 3 cycles per access with a zero-wait slave: IDLE -> BUSY (ack) -> DONE.
//  - DM and IM requesting in the same IDLE cycle: DM is served; IM stays stalled and is served next.
//  - Back-to-back DM accesses pass through IDLE for 1 cycle between accesses.
//  - The timeout counter saturates, clears on every state entry, and is inactive when TIMEOUT=0.
//  - A bus_ack_i outside BUSY is ignored.
// STRUCTURE
//  defines.v gains:
//  - State encodings `BusIdle, `BusBusyD, `BusBusyI, `BusDoneD, `BusDoneI.
//  - `BusWidth, reusing `RegBus.
//  One sub-module, bus_timeout_cnt, with ports clk, rst, clr, en, expired; its width is $clog2(TIMEOUT+1).
//  The FSM, request mux and read buffers live in mem_bus_arbiter.
// TESTING
//  1. Zero-wait LW to 0x100; slave returns 0xDEADBEEF:
//     - cyc is high for 1 cycle.
//     - stallreq_mem_o is 1 for 2 cycles.
//     - dm_data_o=0xDEADBEEF in DONE_D.
//  2. SB with sel=4'b0100 and 3 wait states:
//     - bus_we_o=1 and bus_sel_o=0100, held stable for 4 cycles.
//     - dm_data_o stays unchanged.
//  3. DM and IM raised in the same cycle:
//     - The DM transfer appears on the bus first.
//     - The IM transfer starts 2 cycles after the DM ack; stallreq_if_o stays 1 throughout.
//  4. flush_i pulses mid-BUSY_I:
//     - The transfer completes on ack, then the FSM returns to IDLE.
//     - im_data_o keeps its old value and no DONE_I state is entered.
//  5. TIMEOUT=4 and the slave never acks:
//     - bus_err_o pulses at the 4th BUSY cycle.
//     - dm_data_o=0 and stallreq_mem_o falls.
//  6. rst=0 during a BUSY_D wait:
//     - All outputs are 0 on the next cycle.
//     - After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encodings, bus width
// and the timeout counter sizing helper.
package mem_bus_arbiter_pkg;

   localparam int         BUS_WIDTH = 32;
   localparam logic [3:0] SEL_ALL   = 4'b1111;

   typedef enum logic [2:0] {
      BUS_IDLE   = 3'd0,
      BUS_BUSY_D = 3'd1,
      BUS_BUSY_I = 3'd2,
      BUS_DONE_D = 3'd3,
      BUS_DONE_I = 3'd4
   } bus_state_t;

   // A TIMEOUT of 0 still needs a 1-bit counter so the port stays legal.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Bus watchdog: counts busy cycles and flags the cycle the count reaches TIMEOUT-1.
// Zero latency on expired; cleared whenever the arbiter is not in a busy state.
module bus_timeout_cnt
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int             W    = cnt_width(TIMEOUT);
   localparam logic [W-1:0]   LAST = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [W-1:0]   SAT  = {W{1'b1}};

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst || clr || (TIMEOUT == 0)) begin
         cnt <= '0;
      end else if (en && (cnt != SAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises data (DM) and fetch (IM) accesses onto one ack-terminated bus; DM wins ties.
// Min 3 cycles per access; stalls the pipeline via stallreq_* until each access reaches DONE.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dm_ce_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [3:0]  dm_sel_i,
   input  logic [31:0] dm_data_i,
   output logic [31:0] dm_data_o,
   input  logic        im_ce_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   input  logic        hold_i,
   input  logic        flush_i,
   output logic        stallreq_mem_o,
   output logic        stallreq_if_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   bus_state_t           state;
   logic                 flush_seen;
   logic [BUS_WIDTH-1:0] dm_buf;
   logic [BUS_WIDTH-1:0] im_buf;
   logic                 busy;
   logic                 flushed;
   logic                 expired;

   assign busy    = (state == BUS_BUSY_D) || (state == BUS_BUSY_I);
   assign flushed = flush_seen | flush_i;

   bus_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (~busy),
      .en      (busy),
      .expired (expired)
   );

   assign dm_data_o = dm_buf;
   assign im_data_o = im_buf;

   // Reset gating keeps every output at 0 while rst is held, even with ce raised.
   assign stallreq_mem_o = rst & ~flush_i & dm_ce_i & (state != BUS_DONE_D);
   assign stallreq_if_o  = rst & ~flush_i & im_ce_i & (state != BUS_DONE_I);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= BUS_IDLE;
         flush_seen <= 1'b0;
         dm_buf     <= '0;
         im_buf     <= '0;
         bus_cyc_o  <= 1'b0;
         bus_stb_o  <= 1'b0;
         bus_we_o   <= 1'b0;
         bus_addr_o <= '0;
         bus_sel_o  <= '0;
         bus_data_o <= '0;
         bus_err_o  <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            BUS_IDLE: begin
               flush_seen <= 1'b0;
               if (flush_i) begin
                  state <= BUS_IDLE;
               end else if (dm_ce_i) begin
                  bus_cyc_o  <= 1'b1;
                  bus_stb_o  <= 1'b1;
                  bus_we_o   <= dm_we_i;
                  bus_addr_o <= dm_addr_i;
                  bus_sel_o  <= dm_sel_i;
                  bus_data_o <= dm_data_i;
                  state      <= BUS_BUSY_D;
               end else if (im_ce_i) begin
                  bus_cyc_o  <= 1'b1;
                  bus_stb_o  <= 1'b1;
                  bus_we_o   <= 1'b0;
                  bus_addr_o <= im_addr_i;
                  bus_sel_o  <= SEL_ALL;
                  bus_data_o <= '0;
                  state      <= BUS_BUSY_I;
               end
            end

            BUS_BUSY_D, BUS_BUSY_I: begin
               if (flush_i) begin
                  flush_seen <= 1'b1;
               end
               // An ack in the expiry cycle still counts as a normal completion.
               if (bus_ack_i || expired) begin
                  bus_cyc_o  <= 1'b0;
                  bus_stb_o  <= 1'b0;
                  bus_we_o   <= 1'b0;
                  bus_addr_o <= '0;
                  bus_sel_o  <= '0;
                  bus_data_o <= '0;
                  bus_err_o  <= ~bus_ack_i;
                  if (flushed) begin
                     state <= BUS_IDLE;
                  end else if (state == BUS_BUSY_D) begin
                     if (!bus_ack_i) begin
                        dm_buf <= '0;
                     end else if (!bus_we_o) begin
                        dm_buf <= bus_data_i;
                     end
                     state <= BUS_DONE_D;
                  end else begin
                     im_buf <= bus_ack_i ? bus_data_i : '0;
                     state  <= BUS_DONE_I;
                  end
               end
            end

            BUS_DONE_D, BUS_DONE_I: begin
               if (flush_i || !hold_i) begin
                  state <= BUS_IDLE;
               end
            end

            default: state <= BUS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: directed corner cases, then randomized
// DM/IM/flush traffic against a latency-and-buffer model of the arbiter.
module tb_mem_bus_arbiter;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        dm_ce_i, dm_we_i, im_ce_i, hold_i, flush_i;
   logic [31:0] dm_addr_i, dm_data_i, im_addr_i;
   logic [3:0]  dm_sel_i;
   logic [31:0] dm_data_o, im_data_o;
   logic        stallreq_mem_o, stallreq_if_o;
   logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
   logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
   logic [3:0]  bus_sel_o;
   logic        bus_ack_i;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_sel_i(dm_sel_i),
      .dm_data_i(dm_data_i), .dm_data_o(dm_data_o),
      .im_ce_i(im_ce_i), .im_addr_i(im_addr_i), .im_data_o(im_data_o),
      .hold_i(hold_i), .flush_i(flush_i),
      .stallreq_mem_o(stallreq_mem_o), .stallreq_if_o(stallreq_if_o),
      .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
      .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } bus_txn_t;

   bus_txn_t    bus_q[$];
   logic [31:0] dm_res_q[$];
   logic [31:0] im_res_q[$];
   logic [31:0] dm_last = '0;
   logic [31:0] im_last = '0;
   int          checks = 0;
   int          errors = 0;
   int          err_cycles = 0;
   int          slave_waits = 0;
   bit          slave_mute = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] slave_fn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : ({a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F);
   endfunction

   // Slave: acks after slave_waits wait states, never when muted.
   initial begin : slave
      int wcnt;
      wcnt = 0;
      bus_ack_i  = 1'b0;
      bus_data_i = '0;
      forever begin
         @(posedge clk); #1;
         if (bus_cyc_o && bus_stb_o && !slave_mute && (wcnt >= slave_waits)) begin
            bus_ack_i  = 1'b1;
            bus_data_i = slave_fn(bus_addr_o);
         end else begin
            bus_ack_i  = 1'b0;
            bus_data_i = $urandom;
         end
         if (bus_cyc_o) wcnt++;
         else           wcnt = 0;
      end
   end

   // Bus monitor: each new cycle must match the next queued transfer and stay stable.
   initial begin : bus_mon
      bus_txn_t cur;
      bit       prev;
      prev = 1'b0;
      cur  = '0;
      forever begin
         @(negedge clk);
         if (rst && bus_cyc_o && !prev) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_unexpected_txn: addr %h with nothing queued", bus_addr_o);
            end else begin
               cur = bus_q.pop_front();
               chk("bus_we", 32'(bus_we_o), 32'(cur.we));
               chk("bus_addr", bus_addr_o, cur.addr);
               chk("bus_sel", 32'(bus_sel_o), 32'(cur.sel));
               if (cur.we) chk("bus_wdata", bus_data_o, cur.data);
            end
         end else if (rst && bus_cyc_o) begin
            chk("bus_we_stable", 32'(bus_we_o), 32'(cur.we));
            chk("bus_addr_stable", bus_addr_o, cur.addr);
            chk("bus_sel_stable", 32'(bus_sel_o), 32'(cur.sel));
         end
         if (rst && bus_cyc_o) chk("bus_stb", 32'(bus_stb_o), 32'd1);
         if (bus_err_o) err_cycles++;
         prev = bus_cyc_o;
      end
   end

   // Result monitor: first completion cycle of each request pops the expected read data.
   initial begin : res_mon
      bit dm_seen, im_seen;
      dm_seen = 1'b0;
      im_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && !flush_i) begin
            if (dm_ce_i && !stallreq_mem_o) begin
               if (!dm_seen) begin
                  dm_seen = 1'b1;
                  if (dm_res_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL dm_unexpected_done: dm_data_o %h", dm_data_o);
                  end else chk("dm_data", dm_data_o, dm_res_q.pop_front());
               end
            end else if (!dm_ce_i) dm_seen = 1'b0;
            if (im_ce_i && !stallreq_if_o) begin
               if (!im_seen) begin
                  im_seen = 1'b1;
                  if (im_res_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL im_unexpected_done: im_data_o %h", im_data_o);
                  end else chk("im_data", im_data_o, im_res_q.pop_front());
               end
            end else if (!im_ce_i) im_seen = 1'b0;
         end
      end
   end

   task automatic access(input bit do_dm, input bit do_im, input logic we,
                         input logic [31:0] daddr, input logic [31:0] iaddr,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         input int waits, input int hold_cyc, input bit tmo,
                         output int st_m, output int st_i, output int cyc_n, output bit err_seen);
      bit m_done, i_done;
      int guard;
      @(posedge clk); #1;
      slave_waits = waits;
      slave_mute  = tmo;
      if (do_dm) begin
         bus_q.push_back('{we, daddr, sel, wdata});
         if (tmo)      dm_last = '0;
         else if (!we) dm_last = slave_fn(daddr);
         dm_res_q.push_back(dm_last);
      end
      if (do_im) begin
         bus_q.push_back('{1'b0, iaddr, 4'hF, 32'h0});
         im_last = slave_fn(iaddr);
         im_res_q.push_back(im_last);
      end
      dm_ce_i = do_dm; dm_we_i = we; dm_addr_i = daddr; dm_sel_i = sel; dm_data_i = wdata;
      im_ce_i = do_im; im_addr_i = iaddr;
      hold_i  = (hold_cyc > 0);
      st_m = 0; st_i = 0; cyc_n = 0; err_seen = 1'b0; guard = 0;
      while (dm_ce_i || im_ce_i) begin
         @(negedge clk);
         guard++;
         if (bus_cyc_o) cyc_n++;
         if (bus_err_o) err_seen = 1'b1;
         m_done = dm_ce_i && !stallreq_mem_o;
         i_done = im_ce_i && !stallreq_if_o;
         if (dm_ce_i && stallreq_mem_o) st_m++;
         if (im_ce_i && stallreq_if_o)  st_i++;
         if (guard > 60) begin
            checks++; errors++;
            $display("FAIL access_stuck: stall_mem %b stall_if %b after %0d cycles", stallreq_mem_o, stallreq_if_o, guard);
            dm_ce_i = 1'b0; im_ce_i = 1'b0; hold_i = 1'b0;
            break;
         end
         @(posedge clk); #1;
         if (m_done || i_done) begin
            for (int h = 0; h < hold_cyc; h++) begin
               @(negedge clk);
               chk("hold_keeps_done", 32'(m_done ? stallreq_mem_o : stallreq_if_o), 32'd0);
               @(posedge clk); #1;
            end
            hold_i = 1'b0;
         end
         if (m_done) dm_ce_i = 1'b0;
         if (i_done) im_ce_i = 1'b0;
      end
   endtask

   task automatic flushed_access(input bit is_dm, input logic [31:0] addr, input int waits);
      int guard;
      @(posedge clk); #1;
      slave_waits = waits;
      slave_mute  = 1'b0;
      bus_q.push_back(is_dm ? '{1'b0, addr, 4'hF, 32'h0} : '{1'b0, addr, 4'hF, 32'h0});
      dm_ce_i = is_dm; dm_we_i = 1'b0; dm_addr_i = addr; dm_sel_i = 4'hF; dm_data_i = 32'h0;
      im_ce_i = !is_dm; im_addr_i = addr;
      hold_i  = 1'b1;
      guard = 0;
      while (!bus_cyc_o && guard < 10) begin @(posedge clk); #1; guard++; end
      chk("flush_txn_started", 32'(bus_cyc_o), 32'd1);
      flush_i = 1'b1; dm_ce_i = 1'b0; im_ce_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      guard = 0;
      while (bus_cyc_o && guard < 20) begin @(posedge clk); #1; guard++; end
      chk("flush_txn_ended", 32'(bus_cyc_o), 32'd0);
      chk("flush_keeps_dm", dm_data_o, dm_last);
      chk("flush_keeps_im", im_data_o, im_last);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cyc"}, 32'(bus_cyc_o), 0);
      chk({tag, "_stb"}, 32'(bus_stb_o), 0);
      chk({tag, "_we"}, 32'(bus_we_o), 0);
      chk({tag, "_addr"}, bus_addr_o, 0);
      chk({tag, "_sel"}, 32'(bus_sel_o), 0);
      chk({tag, "_wdata"}, bus_data_o, 0);
      chk({tag, "_err"}, 32'(bus_err_o), 0);
      chk({tag, "_dm_data"}, dm_data_o, 0);
      chk({tag, "_im_data"}, im_data_o, 0);
      chk({tag, "_stall_mem"}, 32'(stallreq_mem_o), 0);
      chk({tag, "_stall_if"}, 32'(stallreq_if_o), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int  sm, si, cn, kind, w, hc;
      bit  es, we;
      logic [31:0] a, d;
      logic [3:0]  sel;
      rst = 1'b0; dm_ce_i = 0; dm_we_i = 0; dm_addr_i = 0; dm_sel_i = 0; dm_data_i = 0;
      im_ce_i = 0; im_addr_i = 0; hold_i = 0; flush_i = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // Zero-wait load
      access(1, 0, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, sm, si, cn, es);
      chk("t1_stall_cycles", sm, 2);
      chk("t1_cyc_cycles", cn, 1);

      // Byte store with 3 wait states: buffer must keep 0xDEADBEEF
      access(1, 0, 1, 32'h204, 0, 4'b0100, 32'h5A5A5A5A, 3, 0, 0, sm, si, cn, es);
      chk("t2_cyc_cycles", cn, 4);
      chk("t2_stall_cycles", sm, 5);
      chk("t2_dm_kept", dm_data_o, 32'hDEADBEEF);

      // Silent slave: abort after TMO busy cycles
      access(1, 0, 0, 32'h300, 0, 4'hF, 0, TMO - 1, 0, 1, sm, si, cn, es);
      chk("t5_cyc_cycles", cn, TMO);
      chk("t5_stall_cycles", sm, TMO + 1);
      chk("t5_err_seen", 32'(es), 1);

      // DM and IM together: DM first, IM stalled throughout
      access(1, 1, 0, 32'h400, 32'h1000, 4'hF, 0, 0, 0, 0, sm, si, cn, es);
      chk("t3_stall_mem", sm, 2);
      chk("t3_stall_if", si, 5);
      chk("t3_cyc_cycles", cn, 2);

      // Flush in the middle of a fetch, then a fetch that must start from IDLE
      flushed_access(0, 32'h2000, 2);
      access(0, 1, 0, 0, 32'h2004, 4'hF, 0, 1, 0, 0, sm, si, cn, es);
      chk("t4_next_stall_if", si, 3);

      // Reset in the middle of a waiting load
      @(posedge clk); #1;
      slave_mute = 1'b1;
      bus_q.push_back('{1'b0, 32'h500, 4'hF, 32'h0});
      dm_ce_i = 1; dm_we_i = 0; dm_addr_i = 32'h500; dm_sel_i = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_busy_before_reset", 32'(bus_cyc_o), 1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("t6_reset");
      @(posedge clk); #1;
      dm_ce_i = 0; slave_mute = 1'b0; dm_last = '0; im_last = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      access(1, 0, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, sm, si, cn, es);
      chk("t6_after_stall", sm, 2);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         w    = $urandom_range(0, 2);
         hc   = $urandom_range(0, 2);
         a    = $urandom & 32'hFFFF_FFFC;
         d    = $urandom;
         we   = $urandom_range(0, 1);
         case ($urandom_range(0, 6))
            0: sel = 4'b0001; 1: sel = 4'b0010; 2: sel = 4'b0100; 3: sel = 4'b1000;
            4: sel = 4'b0011; 5: sel = 4'b1100; default: sel = 4'b1111;
         endcase
         if (kind <= 3) begin
            access(1, 0, we, a, 0, sel, d, w, hc, 0, sm, si, cn, es);
            chk("rnd_dm_stall", sm, w + 2);
            chk("rnd_dm_cyc", cn, w + 1);
         end else if (kind <= 6) begin
            access(0, 1, 0, 0, a, 4'hF, 0, w, hc, 0, sm, si, cn, es);
            chk("rnd_im_stall", si, w + 2);
            chk("rnd_im_cyc", cn, w + 1);
         end else if (kind <= 8) begin
            access(1, 1, we, a, a ^ 32'h8000, sel, d, w, 0, 0, sm, si, cn, es);
            chk("rnd_both_stall_mem", sm, w + 2);
            chk("rnd_both_stall_if", si, 2 * w + 5);
            chk("rnd_both_cyc", cn, 2 * w + 2);
         end else begin
            flushed_access(bit'($urandom_range(0, 1)), a, w);
         end
         if (kind <= 8) chk("rnd_no_err", 32'(es), 0);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("err_pulse_cycles", err_cycles, 1);
      chk("bus_q_drained", 32'(bus_q.size()), 0);
      chk("dm_q_drained", 32'(dm_res_q.size()), 0);
      chk("im_q_drained", 32'(im_res_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
